// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_a, neg_b, dz;
  logic [WIDTH-1:0]   mag_b;   // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc;     // mul: {partial product, multiplier}; div: low half dividend -> quotient
  logic [WIDTH-1:0]   rem;

  // start-time operand conditioning
  logic             sgn_op, neg1, neg2, zero_div;
  logic [WIDTH-1:0] mag1, mag2;
  assign sgn_op   = ~op[0];
  assign neg1     = sgn_op & op1[WIDTH-1];
  assign neg2     = sgn_op & op2[WIDTH-1];
  assign mag1     = neg1 ? -op1 : op1;
  assign mag2     = neg2 ? -op2 : op2;
  assign zero_div = op[1] && (op2 == '0);

  // one iteration step
  logic [WIDTH:0]     mul_sum, shifted;
  logic [WIDTH-1:0]   sub;
  logic               ge;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
  assign shifted = {rem, acc[WIDTH-1]};
  assign ge      = shifted >= {1'b0, mag_b};
  // only consumed when ge, where the true difference is below mag_b and fits WIDTH bits
  assign sub     = shifted[WIDTH-1:0] - mag_b;

  // sign correction
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, dividend;
  assign prod_fix = (neg_a ^ neg_b) ? -acc : acc;
  assign quo_fix  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_a ? -rem : rem;
  assign dividend = neg_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = zero_div ? FIX : CALC;
      CALC: if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      dz      <= 1'b0;
      mag_b   <= '0;
      acc     <= '0;
      rem     <= '0;
      done    <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div  <= op[1];
            neg_a   <= neg1;
            neg_b   <= neg2;
            dz      <= zero_div;
            mag_b   <= op[1] ? mag2 : mag1;
            acc     <= {{WIDTH{1'b0}}, op[1] ? mag1 : mag2};
            rem     <= '0;
            cnt     <= CW'(WIDTH);
            divZero <= 1'b0;
          end else begin
            if (hiWrite) hi <= writeData;
            if (loWrite) lo <= writeData;
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (!is_div) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            rem              <= ge ? sub : shifted[WIDTH-1:0];
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ge};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (dz) begin
            hi      <= dividend;
            lo      <= '1;
            divZero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised + directed bench for mul_div_unit against a plain-arithmetic model.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0, resetN = 1'b0, start = 1'b0, hiWrite = 1'b0, loWrite = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] op1 = '0, op2 = '0, writeData = '0;
  logic         busy, done, divZero;
  logic [W-1:0] hi, lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .resetN(resetN), .start(start), .op(op), .op1(op1), .op2(op2),
    .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
    .busy(busy), .done(done), .divZero(divZero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: MIPS semantics from 64-bit integer arithmetic
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    z  = 1'b0;
    p  = '0;
    h  = '0;
    l  = '0;
    case (o)
      2'b00: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = ua * ub;      h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == '0) begin
          z = 1'b1; h = a; l = '1;
        end else if (o == 2'b10) begin
          l = 32'(sa / sb); h = 32'(sa % sb);
        end else begin
          l = 32'(ua / ub); h = 32'(ua % ub);
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'($urandom_range(0, 15));
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'(-int'($urandom_range(1, 15)));
      default: v = 32'($urandom);
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit disturb, input bit mt);
    logic [W-1:0] eh, el, hi0, lo0;
    logic         ez;
    int           n;
    model(o, a, b, eh, el, ez);
    @(negedge clk);
    hi0 = hi; lo0 = lo;
    op = o; op1 = a; op2 = b; start = 1'b1;
    if (mt) begin loWrite = 1'b1; writeData = 32'h5A5A_5A5A; end
    @(posedge clk); #1;
    start = 1'b0; loWrite = 1'b0;
    op1 = 32'($urandom); op2 = 32'($urandom); op = 2'($urandom_range(0, 3));
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("divzero_cleared", 64'(divZero), 64'(0));
    chk("hi_hold", 64'(hi), 64'(hi0));
    chk("lo_hold", 64'(lo), 64'(lo0));
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (disturb && n == 5) begin
        start = 1'b1; hiWrite = 1'b1; writeData = 32'hDEAD_BEEF; op = 2'b11;
      end else if (disturb && n == 6) begin
        start = 1'b0; hiWrite = 1'b0;
      end
    end
    chk("latency", 64'(n), ez ? 64'(1) : 64'(W + 1));
    chk("busy_in_done", 64'(busy), 64'(0));
    chk("hi", 64'(hi), 64'(eh));
    chk("lo", 64'(lo), 64'(el));
    chk("divzero", 64'(divZero), 64'(ez));
  endtask

  initial begin
    int ndone;
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_divzero", 64'(divZero), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    @(negedge clk); resetN = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b11, 32'h0000_1234, 32'd0, 0, 0);
    run_op(2'b00, 32'd5, 32'd5, 1, 0);

    // MTLO, then simultaneous MTHI/MTLO
    @(negedge clk); loWrite = 1'b1; writeData = 32'hA5A5_A5A5;
    @(posedge clk); #1; loWrite = 1'b0;
    chk("mtlo", 64'(lo), 64'h0000_0000_A5A5_A5A5);
    @(negedge clk); loWrite = 1'b1; hiWrite = 1'b1; writeData = 32'h1357_9BDF;
    @(posedge clk); #1; loWrite = 1'b0; hiWrite = 1'b0;
    chk("mt_both_hi", 64'(hi), 64'h0000_0000_1357_9BDF);
    chk("mt_both_lo", 64'(lo), 64'h0000_0000_1357_9BDF);

    // start and MTLO in the same cycle: start wins
    run_op(2'b01, 32'd3, 32'd4, 0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      run_op(2'($urandom_range(0, 3)), a, b, 0, 0);
    end

    // reset mid-divide aborts with no done
    @(negedge clk); op = 2'b10; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    @(negedge clk); resetN = 1'b1;
    ndone = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
